// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of a PSRAM controller: one read burst or single-word write at a time.
// Define PSRAM_ARB_RR_EN for round-robin on simultaneous requests; otherwise port 0 has priority.
module psram_arbiter (
  input  logic        clk_100,
  input  logic        reset,

  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [22:0] p0_addr,
  input  logic [7:0]  p0_len,
  input  logic [15:0] p0_wdata,
  input  logic        p0_ub,
  input  logic        p0_lb,
  output logic        p0_gnt,
  output logic        p0_dok,
  output logic [15:0] p0_rdata,
  output logic        p0_done,

  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [22:0] p1_addr,
  input  logic [7:0]  p1_len,
  input  logic [15:0] p1_wdata,
  input  logic        p1_ub,
  input  logic        p1_lb,
  output logic        p1_gnt,
  output logic        p1_dok,
  output logic [15:0] p1_rdata,
  output logic        p1_done,

  output logic [22:0] app_addr,
  output logic [15:0] app_data_in,
  output logic        app_ub,
  output logic        app_lb,
  output logic        app_rd,
  output logic        app_wr,
  output logic        app_burst_op,
  input  logic        app_data_ok,
  input  logic        app_op_begun,
  input  logic        op_finished,
  input  logic        app_ctrlr_good,
  input  logic [15:0] app_data_out
);

  typedef enum logic [1:0] {StIdle, StIssue, StXfer, StDone} state_e;

  state_e      state_q, state_d;
  logic        owner_q;   // 0 = port 0, 1 = port 1
  logic        wr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic        phase_q;
  logic [22:0] addr_q;
  logic [15:0] wdata_q;
  logic        ub_q;
  logic        lb_q;
  logic [15:0] rdata0_q;
  logic [15:0] rdata1_q;

  logic        take;
  logic        win;
  logic        strobe;
  logic        win_wr;
  logic [7:0]  win_len;

  // Reads are 1..128 words; writes are always a single word.
  function automatic logic [7:0] eff_len(input logic wr, input logic [7:0] len);
    if (wr || len == 8'd0) begin
      return 8'd1;
    end else if (len > 8'd128) begin
      return 8'd128;
    end
    return len;
  endfunction

`ifdef PSRAM_ARB_RR_EN
  logic last_q;

  always_comb begin
    win = p1_req;
    if (p0_req && p1_req) begin
      win = ~last_q;
    end
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (state_q == StDone) begin
      last_q <= owner_q;
    end
  end
`else
  always_comb begin
    win = ~p0_req;
  end
`endif

  assign take    = (state_q == StIdle) && app_ctrlr_good && (p0_req || p1_req);
  assign win_wr  = win ? p1_wr : p0_wr;
  assign win_len = eff_len(win_wr, win ? p1_len : p0_len);
  // Controller signals two data_ok cycles per word; only the first one is the word strobe.
  assign strobe  = (state_q == StXfer) && app_data_ok && !phase_q;

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (take) state_d = StIssue;
      StIssue: if (app_op_begun) state_d = StXfer;
      StXfer:  if (op_finished) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      len_q    <= 8'd0;
      cnt_q    <= 8'd0;
      phase_q  <= 1'b0;
      addr_q   <= 23'd0;
      wdata_q  <= 16'd0;
      ub_q     <= 1'b0;
      lb_q     <= 1'b0;
      rdata0_q <= 16'd0;
      rdata1_q <= 16'd0;
    end else begin
      if (take) begin
        owner_q <= win;
        wr_q    <= win_wr;
        len_q   <= win_len;
        cnt_q   <= 8'd0;
        addr_q  <= win ? p1_addr : p0_addr;
        wdata_q <= win ? p1_wdata : p0_wdata;
        ub_q    <= win ? p1_ub : p0_ub;
        lb_q    <= win ? p1_lb : p0_lb;
      end else if (strobe && cnt_q != 8'hff) begin
        cnt_q <= cnt_q + 8'd1;
      end

      if (state_q == StIssue) begin
        phase_q <= 1'b0;
      end else if (app_data_ok) begin
        phase_q <= ~phase_q;
      end

      if (strobe && !wr_q) begin
        if (owner_q) begin
          rdata1_q <= app_data_out;
        end else begin
          rdata0_q <= app_data_out;
        end
      end
    end
  end

  always_comb begin
    p0_gnt       = 1'b0;
    p1_gnt       = 1'b0;
    p0_dok       = 1'b0;
    p1_dok       = 1'b0;
    p0_done      = 1'b0;
    p1_done      = 1'b0;
    app_rd       = 1'b0;
    app_wr       = 1'b0;
    app_burst_op = 1'b0;
    if (state_q != StIdle) begin
      p0_gnt = ~owner_q;
      p1_gnt = owner_q;
    end
    if (strobe) begin
      p0_dok = ~owner_q;
      p1_dok = owner_q;
    end
    if (state_q == StDone) begin
      p0_done = ~owner_q;
      p1_done = owner_q;
    end
    if (state_q == StIssue) begin
      app_rd = ~wr_q;
      app_wr = wr_q;
    end
    // Uses the registered count so the continue decision lags the strobe by one cycle.
    if ((state_q == StIssue || state_q == StXfer) && !wr_q && cnt_q < len_q) begin
      app_burst_op = 1'b1;
    end
  end

  assign app_addr    = addr_q;
  assign app_data_in = wdata_q;
  assign app_ub      = ub_q;
  assign app_lb      = lb_q;
  assign p0_rdata    = rdata0_q;
  assign p1_rdata    = rdata1_q;

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface (N = 0,1; two identical requester ports)
REQ-001 clk_100  in  1  controller clock (100MHz); all logic on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high.
REQ-003 pN_req  in  1  request; held high until pN_gnt.
REQ-004 pN_wr  in  1  1 = single-word write, 0 = read.
REQ-005 pN_addr  in  23  start word address.
REQ-006 pN_len  in  8  read burst length 1..128; 0 treated as 1; ignored for writes (forced 1).
REQ-007 pN_wdata / pN_ub / pN_lb  in  16/1/1  write data and byte enables.
REQ-008 pN_gnt  out  1  port owns the controller.
REQ-009 pN_dok  out  1  one-cycle word strobe; read data valid on pN_rdata next cycle, or write data accepted.
REQ-010 pN_rdata  out  16  registered read word.
REQ-011 pN_done  out  1  one-cycle end-of-operation pulse.
REQ-012 app_addr / app_data_in / app_ub / app_lb  out  23/16/1/1  to controller, registered from the winner at grant.
REQ-013 app_rd / app_wr / app_burst_op  out  1  controller strobes.
REQ-014 app_data_ok / app_op_begun / op_finished / app_ctrlr_good  in  1  controller status.
REQ-015 app_data_out  in  16  controller read data.

Function
REQ-016 FSM states: IDLE, ISSUE, XFER, DONE.
REQ-017 IDLE: no grant while app_ctrlr_good=0; otherwise, on any pN_req, latch winner's addr/data/ub/lb/wr/len, assert winner's gnt, go to ISSUE.
REQ-018 ISSUE: drive app_rd (read) or app_wr (write) high until app_op_begun is seen, then drop it in the following cycle and go to XFER.
REQ-019 Word strobe: cycle in XFER with app_data_ok=1 and phase=0; phase toggles on every app_data_ok cycle and clears in ISSUE.
REQ-020 On each word strobe: word counter cnt (8 bit) increments, pN_dok pulses, pN_rdata <= app_data_out (reads only).
REQ-021 app_burst_op = 1 iff read and cnt < len (registered cnt, so the controller's continue decision follows the strobe); always 0 for writes.
REQ-022 XFER: on op_finished go to DONE; DONE pulses pN_done for one cycle, drops pN_gnt, updates last-served pointer, returns to IDLE.
REQ-023 pN_gnt high from ISSUE entry through DONE, exactly one port at a time.
REQ-024 Request changes during a grant do not affect the active operation; a requester may re-assert pN_req immediately after pN_done.
REQ-025 len=128 produces exactly 128 strobes; cnt does not wrap.

Reset
REQ-026 Reset asserted mid-operation returns immediately to IDLE; all outputs 0 (app_addr 0, rdata 0), cnt 0, phase 0, last-served pointer = port 1.

Configuration
REQ-027 Macro PSRAM_ARB_RR_EN defined: round-robin; on simultaneous requests the port not last served wins.
REQ-028 PSRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-029 app_ctrlr_good=0, p0_req=1 -> no gnt, app_rd=0; after good=1 -> p0_gnt next cycle, app_rd until app_op_begun.
REQ-030 p0 read addr 0x000100 len 4 -> 4 p0_dok pulses, app_burst_op low after 4th strobe, single p0_done, rdata matches model.
REQ-031 p1 write addr 0x7FFFFF data 0xA55A ub=1 lb=0 len 9 -> app_wr, app_burst_op never high, exactly 1 p1_dok, p1_done.
REQ-032 p0 and p1 both requesting continuously, RR_EN defined -> grants alternate p0,p1,p0,p1; undefined -> p0 only.
REQ-033 reset pulsed during 3rd word of 8-word read -> all gnt/dok/done/app_* 0 next edge, FSM IDLE, new request served normally.
REQ-034 p0 len 0 -> treated as 1: one p0_dok, app_burst_op never high.
